unidade_controle: RTL and testbench

UNIDADE_CONTROLE -- requirements
Module: unidade_controle

---
 rtl/unidade_controle_pkg.sv | 66 ++++++
 rtl/unidade_controle_decod_ula.sv | 27 ++
 rtl/unidade_controle.sv | 151 +++++++++++++++
 tb/tb_unidade_controle.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/unidade_controle_pkg.sv
// Shared types for the multicycle control unit: FSM states, opcodes and
// the encodings of the ULA operation, ALU B-source and result-select buses.
// Optional feature macro: UNIDADE_CONTROLE_JUMP_EN adds the JUMP state/opcode.
package unidade_controle_pkg;

  localparam int unsigned STATE_W = 4;
  localparam int unsigned OPC_W   = 4;
  localparam int unsigned FUNCT_W = 3;
  localparam int unsigned ULA_W   = 3;
  localparam int unsigned SRCB_W  = 2;
  localparam int unsigned RES_W   = 2;

  typedef enum logic [STATE_W-1:0] {
    S_INICIO   = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEMADR   = 4'd3,
    S_MEMREAD  = 4'd4,
    S_MEMWB    = 4'd5,
    S_MEMWRITE = 4'd6,
    S_EXECR    = 4'd7,
    S_ALUWB    = 4'd8,
    S_EXECI    = 4'd9,
    S_BEQ      = 4'd10,
`ifdef UNIDADE_CONTROLE_JUMP_EN
    S_JUMP     = 4'd12,
`endif
    S_PARADO   = 4'd11
  } state_t;

  typedef enum logic [OPC_W-1:0] {
    OP_RTYPE = 4'h0,
    OP_LW    = 4'h1,
    OP_SW    = 4'h2,
    OP_BEQ   = 4'h3,
    OP_ADDI  = 4'h4,
    OP_JUMP  = 4'h5
  } opcode_t;

  typedef enum logic [ULA_W-1:0] {
    ULA_ADD = 3'b000,
    ULA_SUB = 3'b001,
    ULA_AND = 3'b010,
    ULA_OR  = 3'b011,
    ULA_XOR = 3'b100,
    ULA_SLT = 3'b101
  } ula_op_t;

  typedef enum logic [SRCB_W-1:0] {
    SRCB_B   = 2'b00,
    SRCB_ONE = 2'b01,
    SRCB_IMM = 2'b10
  } srcb_t;

  typedef enum logic [RES_W-1:0] {
    RES_ALUOUT = 2'b00,
    RES_MEM    = 2'b01,
    RES_ULA    = 2'b10
  } res_t;

  // Funct codes above SLT have no ULA operation behind them.
  function automatic logic funct_legal(input logic [FUNCT_W-1:0] funct);
    return funct <= FUNCT_W'(ULA_SLT);
  endfunction

endpackage

// File: rtl/unidade_controle_decod_ula.sv
// ULA operation decoder.
// Ports: state (current FSM state), funct (R-type field) ->
//        ula_control (ULA operation), illegal_funct (unsupported funct in EXECR).
module decod_ula
  import unidade_controle_pkg::*;
(
  input  state_t             state,
  input  logic [FUNCT_W-1:0] funct,
  output logic [ULA_W-1:0]   ula_control,
  output logic               illegal_funct
);

  // Add is the idle operation; EXECR forwards funct, BEQ compares by subtraction.
  always_comb begin
    ula_control   = ULA_ADD;
    illegal_funct = 1'b0;
    case (state)
      S_EXECR: begin
        if (funct_legal(funct)) ula_control = funct;
        else                    illegal_funct = 1'b1;
      end
      S_BEQ:   ula_control = ULA_SUB;
      default: ula_control = ULA_ADD;
    endcase
  end

endmodule

// File: rtl/unidade_controle.sv
// Multicycle processor control unit (Moore FSM).
// Ports: clk, rst_n (async active-low); Opcode/Funct from the IR, Zero from
//        the ULA; datapath controls ULAControl, ALUSrcA, ALUSrcB, ResultSrc,
//        IorD, IRWrite, MemWrite, RegWrite, PCEn; status IllegalOp, Halted,
//        State (debug view of the state register).
// Parameter HALT_OP selects the opcode that parks the sequencer.
// Macro UNIDADE_CONTROLE_JUMP_EN enables opcode 0101 (JUMP).
module unidade_controle
  import unidade_controle_pkg::*;
#(
  parameter logic [OPC_W-1:0] HALT_OP = 4'hF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [OPC_W-1:0]   Opcode,
  input  logic [FUNCT_W-1:0] Funct,
  input  logic               Zero,
  output logic [ULA_W-1:0]   ULAControl,
  output logic               ALUSrcA,
  output logic [SRCB_W-1:0]  ALUSrcB,
  output logic [RES_W-1:0]   ResultSrc,
  output logic               IorD,
  output logic               IRWrite,
  output logic               MemWrite,
  output logic               RegWrite,
  output logic               PCEn,
  output logic               IllegalOp,
  output logic               Halted,
  output logic [STATE_W-1:0] State
);

  state_t state, state_next;
  logic   armed;
  logic   pc_update, branch;
  logic   illegal_opc, illegal_funct;

  // armed delays the INICIO->FETCH step by one edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_INICIO;
      armed <= 1'b0;
    end else begin
      state <= state_next;
      armed <= 1'b1;
    end
  end

  // Next state and state-decoded controls.
  always_comb begin
    state_next  = state;
    ALUSrcA     = 1'b0;
    ALUSrcB     = SRCB_B;
    ResultSrc   = RES_ALUOUT;
    IorD        = 1'b0;
    IRWrite     = 1'b0;
    MemWrite    = 1'b0;
    RegWrite    = 1'b0;
    Halted      = 1'b0;
    pc_update   = 1'b0;
    branch      = 1'b0;
    illegal_opc = 1'b0;
    case (state)
      S_INICIO: begin
        if (armed) state_next = S_FETCH;
      end
      S_FETCH: begin
        ALUSrcB    = SRCB_ONE;
        ResultSrc  = RES_ULA;
        IRWrite    = 1'b1;
        pc_update  = 1'b1;
        state_next = S_DECODE;
      end
      S_DECODE: begin
        // Branch target is computed into ALUOut while the opcode is decoded.
        ALUSrcB = SRCB_IMM;
        if (Opcode == OP_RTYPE)                       state_next = S_EXECR;
        else if (Opcode == OP_LW || Opcode == OP_SW)  state_next = S_MEMADR;
        else if (Opcode == OP_BEQ)                    state_next = S_BEQ;
        else if (Opcode == OP_ADDI)                   state_next = S_EXECI;
`ifdef UNIDADE_CONTROLE_JUMP_EN
        else if (Opcode == OP_JUMP)                   state_next = S_JUMP;
`endif
        else if (Opcode == HALT_OP)                   state_next = S_PARADO;
        else begin
          illegal_opc = 1'b1;
          state_next  = S_FETCH;
        end
      end
      S_MEMADR: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = SRCB_IMM;
        state_next = (Opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        IorD       = 1'b1;
        state_next = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc  = RES_MEM;
        RegWrite   = 1'b1;
        state_next = S_FETCH;
      end
      S_MEMWRITE: begin
        IorD       = 1'b1;
        MemWrite   = 1'b1;
        state_next = S_FETCH;
      end
      S_EXECR: begin
        ALUSrcA    = 1'b1;
        state_next = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = SRCB_IMM;
        state_next = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite   = 1'b1;
        state_next = S_FETCH;
      end
      S_BEQ: begin
        ALUSrcA    = 1'b1;
        branch     = 1'b1;
        state_next = S_FETCH;
      end
`ifdef UNIDADE_CONTROLE_JUMP_EN
      S_JUMP: begin
        pc_update  = 1'b1;
        state_next = S_FETCH;
      end
`endif
      S_PARADO: begin
        Halted = 1'b1;
      end
      default: state_next = S_INICIO;
    endcase
  end

  decod_ula u_decod_ula (
    .state         (state),
    .funct         (Funct),
    .ula_control   (ULAControl),
    .illegal_funct (illegal_funct)
  );

  // PCEn is the one control allowed to see Zero combinationally.
  assign PCEn      = pc_update | (branch & Zero);
  assign IllegalOp = illegal_opc | illegal_funct;
  assign State     = state;

endmodule

// File: tb/tb_unidade_controle.sv
// Self-checking bench for unidade_controle: per-cycle expected control words
// are queued with each instruction and compared on the falling clock edge.
module tb_unidade_controle;
  import unidade_controle_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] opcode;
  logic [2:0] funct;
  logic       zero;
  logic [2:0] ula_control;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] result_src;
  logic       iord, ir_write, mem_write, reg_write, pc_en, illegal_op, halted;
  logic [3:0] state;
  logic [18:0] obs;

  int checks = 0;
  int fails  = 0;

  logic [18:0] exp_q[$];
  string       tag_q[$];

  always #5 clk = ~clk;

  unidade_controle #(.HALT_OP(4'hF)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .Opcode     (opcode),
    .Funct      (funct),
    .Zero       (zero),
    .ULAControl (ula_control),
    .ALUSrcA    (alu_src_a),
    .ALUSrcB    (alu_src_b),
    .ResultSrc  (result_src),
    .IorD       (iord),
    .IRWrite    (ir_write),
    .MemWrite   (mem_write),
    .RegWrite   (reg_write),
    .PCEn       (pc_en),
    .IllegalOp  (illegal_op),
    .Halted     (halted),
    .State      (state)
  );

  assign obs = {state, ula_control, alu_src_a, alu_src_b, result_src,
                iord, ir_write, mem_write, reg_write, pc_en, illegal_op, halted};

  // flags = {IorD, IRWrite, MemWrite, RegWrite, PCEn, IllegalOp, Halted}
  function automatic logic [18:0] rec(input state_t s, input logic [2:0] ula,
                                      input logic a, input logic [1:0] b,
                                      input logic [1:0] r, input logic [6:0] flags);
    return {4'(s), ula, a, b, r, flags};
  endfunction

  function automatic void push(input logic [18:0] v, input string t);
    exp_q.push_back(v);
    tag_q.push_back(t);
  endfunction

  function automatic logic [18:0] e_fetch();  return rec(S_FETCH, 3'b000, 1'b0, 2'b01, 2'b10, 7'b0100100); endfunction
  function automatic logic [18:0] e_decode(); return rec(S_DECODE, 3'b000, 1'b0, 2'b10, 2'b00, 7'b0000000); endfunction
  function automatic logic [18:0] e_dec_ill(); return rec(S_DECODE, 3'b000, 1'b0, 2'b10, 2'b00, 7'b0000010); endfunction
  function automatic logic [18:0] e_memadr(); return rec(S_MEMADR, 3'b000, 1'b1, 2'b10, 2'b00, 7'b0000000); endfunction
  function automatic logic [18:0] e_memread(); return rec(S_MEMREAD, 3'b000, 1'b0, 2'b00, 2'b00, 7'b1000000); endfunction
  function automatic logic [18:0] e_memwb();  return rec(S_MEMWB, 3'b000, 1'b0, 2'b00, 2'b01, 7'b0001000); endfunction
  function automatic logic [18:0] e_memwr();  return rec(S_MEMWRITE, 3'b000, 1'b0, 2'b00, 2'b00, 7'b1010000); endfunction
  function automatic logic [18:0] e_execi();  return rec(S_EXECI, 3'b000, 1'b1, 2'b10, 2'b00, 7'b0000000); endfunction
  function automatic logic [18:0] e_aluwb();  return rec(S_ALUWB, 3'b000, 1'b0, 2'b00, 2'b00, 7'b0001000); endfunction
  function automatic logic [18:0] e_parado(); return rec(S_PARADO, 3'b000, 1'b0, 2'b00, 2'b00, 7'b0000001); endfunction

  task automatic test_reset();
    logic [18:0] e;
    string t;
    rst_n = 1'b0; opcode = 4'h0; funct = 3'b000; zero = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) push(19'd0, "in_reset");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); t = tag_q.pop_front();
      checks++;
      if (obs !== e) begin fails++; $display("FAIL reset %s: got %b want %b", t, obs, e); end
      @(negedge clk);
    end
    rst_n = 1'b1;
    push(19'd0, "release_pre_edge");
    push(19'd0, "release_edge1");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); t = tag_q.pop_front();
      checks++;
      if (obs !== e) begin fails++; $display("FAIL reset %s: got %b want %b", t, obs, e); end
      @(negedge clk);
    end
  endtask

  task automatic test_rtype(input logic [2:0] f);
    logic [18:0] e;
    string t;
    logic bad;
    bad = (f > 3'b101);
    opcode = 4'h0; funct = f;
    push(e_fetch(), "fetch");
    push(e_decode(), "decode");
    push(rec(S_EXECR, bad ? 3'b000 : f, 1'b1, 2'b00, 2'b00, bad ? 7'b0000010 : 7'b0),
         "execr");
    push(e_aluwb(), "aluwb");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); t = tag_q.pop_front();
      checks++;
      if (obs !== e) begin fails++; $display("FAIL rtype f=%b %s: got %b want %b", f, t, obs, e); end
      @(negedge clk);
    end
  endtask

  task automatic test_addi();
    logic [18:0] e;
    string t;
    opcode = 4'h4; funct = 3'b111;
    push(e_fetch(), "fetch");
    push(e_decode(), "decode");
    push(e_execi(), "execi");
    push(e_aluwb(), "aluwb");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); t = tag_q.pop_front();
      checks++;
      if (obs !== e) begin fails++; $display("FAIL addi %s: got %b want %b", t, obs, e); end
      @(negedge clk);
    end
  endtask

  task automatic test_lw_sw();
    logic [18:0] e;
    string t;
    int memw_count = 0;
    opcode = 4'h1; funct = 3'b000;
    push(e_fetch(), "lw_fetch"); push(e_decode(), "lw_decode");
    push(e_memadr(), "lw_memadr"); push(e_memread(), "lw_memread");
    push(e_memwb(), "lw_memwb");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); t = tag_q.pop_front();
      checks++;
      if (obs !== e) begin fails++; $display("FAIL lw_sw %s: got %b want %b", t, obs, e); end
      @(negedge clk);
    end
    opcode = 4'h2;
    push(e_fetch(), "sw_fetch"); push(e_decode(), "sw_decode");
    push(e_memadr(), "sw_memadr"); push(e_memwr(), "sw_memwrite");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); t = tag_q.pop_front();
      checks++;
      if (mem_write) memw_count++;
      if (obs !== e) begin fails++; $display("FAIL lw_sw %s: got %b want %b", t, obs, e); end
      @(negedge clk);
    end
    checks++;
    if (memw_count !== 1) begin
      fails++; $display("FAIL sw_memwrite_pulses: got %0d want 1", memw_count);
    end
  endtask

  task automatic test_beq(input logic z);
    logic [18:0] e;
    string t;
    opcode = 4'h3; zero = z;
    push(e_fetch(), "fetch");
    push(e_decode(), "decode");
    push(rec(S_BEQ, 3'b001, 1'b1, 2'b00, 2'b00, z ? 7'b0000100 : 7'b0), "beq");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); t = tag_q.pop_front();
      checks++;
      if (obs !== e) begin fails++; $display("FAIL beq z=%b %s: got %b want %b", z, t, obs, e); end
      @(negedge clk);
    end
    zero = 1'b0;
  endtask

  task automatic test_illegal(input logic [3:0] op);
    logic [18:0] e;
    string t;
    opcode = op;
    push(e_fetch(), "fetch");
`ifdef UNIDADE_CONTROLE_JUMP_EN
    if (op == 4'h5) begin
      push(e_decode(), "decode");
      push(rec(S_JUMP, 3'b000, 1'b0, 2'b00, 2'b00, 7'b0000100), "jump");
    end else
      push(e_dec_ill(), "decode_illegal");
`else
    push(e_dec_ill(), "decode_illegal");
`endif
    push(e_fetch(), "back_to_fetch");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); t = tag_q.pop_front();
      checks++;
      if (obs !== e) begin fails++; $display("FAIL illegal op=%h %s: got %b want %b", op, t, obs, e); end
      if (exp_q.size() > 0) @(negedge clk);
    end
  endtask

  task automatic test_halt();
    logic [18:0] e;
    string t;
    opcode = 4'hF;
    push(e_fetch(), "fetch");
    push(e_decode(), "decode");
    for (int i = 0; i < 20; i++) push(e_parado(), "parado");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); t = tag_q.pop_front();
      checks++;
      if (obs !== e) begin fails++; $display("FAIL halt %s: got %b want %b", t, obs, e); end
      @(negedge clk);
    end
  endtask

  task automatic test_midop_reset();
    logic [18:0] e;
    string t;
    // leave PARADO through reset, asserted asynchronously between edges
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== 19'd0) begin fails++; $display("FAIL reset_from_parado: got %b want %b", obs, 19'd0); end
    @(negedge clk);
    rst_n = 1'b1;
    opcode = 4'h1;
    push(19'd0, "inicio0"); push(19'd0, "inicio1");
    push(e_fetch(), "fetch"); push(e_decode(), "decode");
    push(e_memadr(), "memadr"); push(e_memread(), "memread");
    push(e_memwb(), "memwb");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); t = tag_q.pop_front();
      checks++;
      if (obs !== e) begin fails++; $display("FAIL midop %s: got %b want %b", t, obs, e); end
      if (exp_q.size() > 0) @(negedge clk);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== 19'd0) begin fails++; $display("FAIL midop_async_reset: got %b want %b", obs, 19'd0); end
    checks++;
    if (reg_write !== 1'b0) begin fails++; $display("FAIL midop_regwrite: got %b want 0", reg_write); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_rtype(3'b100);
    test_rtype(3'b101);
    test_rtype(3'b110);
    test_rtype(3'b111);
    test_addi();
    test_lw_sw();
    test_beq(1'b1);
    test_beq(1'b0);
    test_illegal(4'h6);
    test_illegal(4'h5);
    test_halt();
    test_midop_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
